psram_bus_bridge: RTL and testbench

Bridges the CPU6 byte-wide system bus (19-bit address, 8-bit data) to the 16-bit PsramController command interface on the Tang Nano 9K. The bridge sits between the CPU/address decode and the PSRAM controller, and runs on the 81 MHz PSRAM clock. It converts single byte read and write requests into controller read/write pulses, selects or replicates bytes within the 16-bit word, and waits on the controller's busy handshake. A one-word read buffer returns repeated reads of the same 16-bit word without a PSRAM access.

---
 rtl/psram_bus_bridge.sv | 147 ++++++++++++++
 tb/tb_psram_bus_bridge.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_bus_bridge.sv
// Byte-wide CPU bus to 16-bit PSRAM controller bridge with a one-word read buffer.
// All outputs are registered; the controller busy handshake paces each access.
module psram_bus_bridge #(
  parameter logic [21:0] ADDR_BASE = 22'h000000,
  parameter bit          BUF_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_byte_write,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [21:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_buf_valid;
  logic [20:0] r_buf_tag;
  logic [15:0] r_buf_data;
  logic [7:0]  r_cpu_rdata;
  logic        r_cpu_ack;
  logic        r_cpu_ready;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_mem_byte_write;
  logic [21:0] r_mem_addr;
  logic [15:0] r_mem_din;

  logic [21:0] w_addr;
  logic        w_hit;
  logic [7:0]  w_buf_byte;
  logic        w_tag_match;

  assign w_addr      = ADDR_BASE + {3'b000, cpu_addr};
  assign w_hit       = BUF_EN && r_buf_valid && (r_buf_tag == w_addr[21:1]);
  assign w_buf_byte  = w_addr[0] ? r_buf_data[15:8] : r_buf_data[7:0];
  assign w_tag_match = r_buf_valid && (r_buf_tag == r_addr[21:1]);

  assign cpu_rdata      = r_cpu_rdata;
  assign cpu_ack        = r_cpu_ack;
  assign cpu_ready      = r_cpu_ready;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_byte_write = r_mem_byte_write;
  assign mem_addr       = r_mem_addr;
  assign mem_din        = r_mem_din;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state          <= S_IDLE;
      r_we             <= 1'b0;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_buf_valid      <= 1'b0;
      r_buf_tag        <= '0;
      r_buf_data       <= '0;
      r_cpu_rdata      <= '0;
      r_cpu_ack        <= 1'b0;
      r_cpu_ready      <= 1'b1;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_byte_write <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_din        <= '0;
    end else begin
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_byte_write <= 1'b0;
      r_cpu_ack        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The ack cycle is spent in IDLE with ready still low; ready rises after it.
          if (r_cpu_ack) begin
            r_cpu_ready <= 1'b1;
          end else if (r_cpu_ready && cpu_req) begin
            r_we        <= cpu_we;
            r_addr      <= w_addr;
            r_wdata     <= cpu_wdata;
            r_cpu_ready <= 1'b0;
            if (!cpu_we && w_hit) begin
              r_cpu_rdata <= w_buf_byte;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (!mem_busy) begin
            r_mem_addr <= r_addr;
            if (r_we) begin
              r_mem_write      <= 1'b1;
              r_mem_byte_write <= 1'b1;
              r_mem_din        <= {r_wdata, r_wdata};
            end else begin
              r_mem_read <= 1'b1;
            end
            r_state <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (mem_busy) r_state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (!mem_busy) begin
            if (!r_we) begin
              r_buf_data  <= mem_dout;
              r_buf_tag   <= r_addr[21:1];
              r_buf_valid <= 1'b1;
              r_cpu_rdata <= r_addr[0] ? mem_dout[15:8] : mem_dout[7:0];
            end else if (w_tag_match) begin
              if (r_addr[0]) r_buf_data[15:8] <= r_wdata;
              else           r_buf_data[7:0]  <= r_wdata;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_cpu_ack <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_bus_bridge.sv
// Bench for psram_bus_bridge: default instance plus a wrapped-base, buffer-less instance,
// each driven against a small PSRAM controller model with a scoreboard of read data.
module tb_psram_bus_bridge;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        cpu_req   [2];
  logic        cpu_we    [2];
  logic [18:0] cpu_addr  [2];
  logic [7:0]  cpu_wdata [2];
  logic [7:0]  cpu_rdata [2];
  logic        cpu_ack   [2];
  logic        cpu_ready [2];
  logic        mem_read  [2];
  logic        mem_write [2];
  logic        mem_bw    [2];
  logic [21:0] mem_addr  [2];
  logic [15:0] mem_din   [2];
  logic [15:0] mem_dout  [2];
  logic        mem_busy  [2];

  psram_bus_bridge u_dut0 (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]), .cpu_ready(cpu_ready[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_byte_write(mem_bw[0]),
    .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_dout(mem_dout[0]), .mem_busy(mem_busy[0])
  );

  psram_bus_bridge #(.ADDR_BASE(22'h3FFFFF), .BUF_EN(1'b0)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]), .cpu_ready(cpu_ready[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_byte_write(mem_bw[1]),
    .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_dout(mem_dout[1]), .mem_busy(mem_busy[1])
  );

  // Controller model: a command starts a 4-cycle busy window; data is presented once busy drops.
  int          busy_cnt  [2] = '{0, 0};
  int          rd_cnt    [2] = '{0, 0};
  int          wr_cnt    [2] = '{0, 0};
  int          viol      [2] = '{0, 0};
  int          ack_total [2] = '{0, 0};
  logic        force_busy[2] = '{1'b0, 1'b0};
  logic [15:0] rd_word   [2] = '{16'hBEEF, 16'hA55A};
  logic [21:0] last_addr [2] = '{22'h0, 22'h0};
  logic [15:0] last_din  [2] = '{16'h0, 16'h0};
  logic        last_bw   [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge resetn) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        busy_cnt[k] <= 0;
      end else begin
        if (cpu_ack[k]) ack_total[k] <= ack_total[k] + 1;
        if (mem_read[k] || mem_write[k]) begin
          if (mem_busy[k] || (mem_read[k] && mem_write[k])) viol[k] <= viol[k] + 1;
          if (mem_read[k])  rd_cnt[k] <= rd_cnt[k] + 1;
          if (mem_write[k]) wr_cnt[k] <= wr_cnt[k] + 1;
          last_addr[k] <= mem_addr[k];
          last_din[k]  <= mem_din[k];
          last_bw[k]   <= mem_bw[k];
          busy_cnt[k]  <= 4;
        end else if (busy_cnt[k] != 0) begin
          busy_cnt[k] <= busy_cnt[k] - 1;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mem_busy[k] = force_busy[k] | (busy_cnt[k] != 0);
      mem_dout[k] = (busy_cnt[k] == 0) ? rd_word[k] : 16'h0000;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic check_reset(input int k);
    check_eq("rst_rdata", cpu_rdata[k], 0);
    check_eq("rst_ack",   cpu_ack[k],   0);
    check_eq("rst_ready", cpu_ready[k], 1);
    check_eq("rst_read",  mem_read[k],  0);
    check_eq("rst_write", mem_write[k], 0);
    check_eq("rst_bw",    mem_bw[k],    0);
    check_eq("rst_addr",  mem_addr[k],  0);
    check_eq("rst_din",   mem_din[k],   0);
  endtask

  // exp_v < 0 marks a write: only the ack is expected, no read data.
  task automatic do_req(input int k, input logic we, input logic [18:0] addr,
                        input logic [7:0] wd, input int exp_v, output int lat);
    int  want;
    bit  done;
    @(negedge clk);
    cpu_req[k] = 1'b1; cpu_we[k] = we; cpu_addr[k] = addr; cpu_wdata[k] = wd;
    exp_q.push_back(exp_v);
    lat = 0;
    done = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        cpu_req[k] = 1'b0;
        check_eq("ready_low", cpu_ready[k], 0);
      end
      if (cpu_ack[k]) begin
        done = 1'b1;
        want = exp_q.pop_front();
        if (want >= 0) check_eq("rdata", cpu_rdata[k], want[7:0]);
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL ack_timeout: no cpu_ack after %0d cycles, expected one", lat);
      void'(exp_q.pop_front());
    end else begin
      @(negedge clk);
      check_eq("ack_one_cycle", cpu_ack[k], 0);
      check_eq("ready_back", cpu_ready[k], 1);
    end
  endtask

  task automatic wait_busy(input int k);
    int n = 0;
    while (!mem_busy[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mem_busy[k]) begin
      n_checks++;
      n_errors++;
      $display("FAIL busy_timeout: mem_busy low after %0d cycles, expected high", n);
    end
  endtask

  // A second request during WAIT_LO must be ignored.
  task automatic drop_test(input int k, input logic [18:0] addr, input int exp_v);
    int lat, acks0, rd0;
    acks0 = ack_total[k];
    rd0   = rd_cnt[k];
    fork
      do_req(k, 1'b0, addr, 8'h00, exp_v, lat);
      begin
        @(negedge clk);
        @(negedge clk);
        wait_busy(k);
        @(negedge clk);
        cpu_req[k] = 1'b1; cpu_we[k] = 1'b1; cpu_addr[k] = 19'h00077; cpu_wdata[k] = 8'hC7;
        @(negedge clk);
        cpu_req[k] = 1'b0;
      end
    join
    repeat (12) @(negedge clk);
    check_eq("drop_acks", ack_total[k] - acks0, 1);
    check_eq("drop_reads", rd_cnt[k] - rd0, 1);
    check_eq("drop_ready", cpu_ready[k], 1);
  endtask

  initial begin
    int lat, rd0, wr0;
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    resetn = 1'b1;
    @(negedge clk);

    // Read miss, upper byte
    rd0 = rd_cnt[0];
    do_req(0, 1'b0, 19'h00011, 8'h00, 8'hBE, lat);
    check_eq("miss_reads", rd_cnt[0] - rd0, 1);
    check_eq("miss_addr", last_addr[0], 22'h000011);
    check_eq("addr_hold", mem_addr[0], 22'h000011);

    // Same-word read hits the buffer with 2-cycle latency
    rd0 = rd_cnt[0];
    do_req(0, 1'b0, 19'h00010, 8'h00, 8'hEF, lat);
    check_eq("hit_latency", lat, 2);
    check_eq("hit_reads", rd_cnt[0] - rd0, 0);

    // Write-through updates the buffered lower byte only
    wr0 = wr_cnt[0];
    do_req(0, 1'b1, 19'h00010, 8'h5A, -1, lat);
    check_eq("wr_pulses", wr_cnt[0] - wr0, 1);
    check_eq("wr_bw", last_bw[0], 1);
    check_eq("wr_din", last_din[0], 16'h5A5A);
    check_eq("wr_addr", last_addr[0], 22'h000010);
    check_eq("din_hold", mem_din[0], 16'h5A5A);
    rd0 = rd_cnt[0];
    do_req(0, 1'b0, 19'h00010, 8'h00, 8'h5A, lat);
    do_req(0, 1'b0, 19'h00011, 8'h00, 8'hBE, lat);
    check_eq("wt_hit_reads", rd_cnt[0] - rd0, 0);

    // Busy stall: no command while the controller is busy
    rd0 = rd_cnt[0];
    force_busy[0] = 1'b1;
    fork
      do_req(0, 1'b0, 19'h00020, 8'h00, 8'hEF, lat);
      begin
        repeat (10) @(negedge clk);
        check_eq("stall_no_cmd", rd_cnt[0] - rd0, 0);
        force_busy[0] = 1'b0;
      end
    join
    check_eq("stall_one_cmd", rd_cnt[0] - rd0, 1);

    rd_word[0] = 16'h1234;
    drop_test(0, 19'h00041, 8'h12);

    // Reset during WAIT_LO invalidates the buffer
    do_req(0, 1'b0, 19'h00010, 8'h00, 8'h34, lat);
    @(negedge clk);
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 19'h00030;
    @(negedge clk);
    cpu_req[0] = 1'b0;
    wait_busy(0);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset(0);
    @(negedge clk);
    resetn = 1'b1;
    rd_word[0] = 16'hC3D4;
    rd0 = rd_cnt[0];
    do_req(0, 1'b0, 19'h00010, 8'h00, 8'hD4, lat);
    check_eq("post_rst_reads", rd_cnt[0] - rd0, 1);

    // Wrapped base address, buffer disabled
    rd0 = rd_cnt[1];
    do_req(1, 1'b0, 19'h00001, 8'h00, 8'h5A, lat);
    check_eq("wrap_addr", last_addr[1], 22'h000000);
    do_req(1, 1'b0, 19'h00001, 8'h00, 8'h5A, lat);
    check_eq("nobuf_reads", rd_cnt[1] - rd0, 2);
    drop_test(1, 19'h00001, 8'h5A);

    check_eq("proto_viol0", viol[0], 0);
    check_eq("proto_viol1", viol[1], 0);
    check_eq("q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
